cyclic_sr_loader: RTL and testbench

- Upstream feeder for the cyclic parallel-in shift register stage.
- Accepts WIDTH-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Drives the shift register's parallel data `D` and mode select `en`: en=1 means parallel load, en=0 means rotate.
- Each word is loaded for one cycle, then left to rotate for ROT_CYCLES cycles before the next word is loaded.

---
 rtl/cyclic_sr_loader_pkg.sv | 19 +
 rtl/cyclic_sr_loader_if.sv | 16 +
 rtl/cyclic_sr_loader_fifo.sv | 56 +++++
 rtl/cyclic_sr_loader.sv | 123 ++++++++++++
 tb/tb_cyclic_sr_loader.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cyclic_sr_loader_pkg.sv
// cyclic_sr_pkg -- shared definitions for the cyclic shift-register loader.
//   state_t    : loader FSM encoding (IDLE/LOAD/ROTATE)
//   DEF_WIDTH  : default word width, shared with the shift register stage
//   cnt_w()    : width of a down-counter that must hold n-1 (min 1 bit)
package cyclic_sr_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ROTATE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cyclic_sr_loader_if.sv
// cyclic_sr_loader_if -- word input handshake into the loader.
//   in_data  : word to enqueue (master -> slave)
//   in_valid : in_data valid this cycle (master -> slave)
//   in_ready : loader can take a word this cycle (slave -> master)
interface cyclic_sr_loader_if
  import cyclic_sr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cyclic_sr_loader_fifo.sv
// sync_fifo -- single-clock FIFO with registered occupancy.
//   clk, reset : clock, async active-low reset
//   clr        : synchronous clear (pointers and level to 0, wins over push/pop)
//   push/din   : write din when not full
//   pop/dout   : dout is the head word; pop advances it when not empty
//   level      : occupancy 0..DEPTH; full/empty decoded from it
// DEPTH must be a power of 2 (>= 2) so pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; contents are only observed after a write.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr] <= din;
  end

endmodule

// File: rtl/cyclic_sr_loader.sv
// cyclic_sr_loader -- feeds a cyclic parallel-in shift register.
// Words arrive over a valid/ready handshake, are buffered in sync_fifo, then
// each word is presented on D with en=1 for one cycle (parallel load) followed
// by ROT_CYCLES cycles of en=0 (rotate). Back-to-back words load with no gap.
//   clk, reset : clock, async active-low reset
//   flush      : (only with `define CYCLIC_LOADER_FLUSH_EN) sync clear of FIFO+FSM
//   bus        : in_data/in_valid/in_ready handshake (slave modport)
//   D, en      : registered parallel data / load select to the shift register
//   busy       : FSM not idle (registered)
//   level      : FIFO occupancy
module cyclic_sr_loader
  import cyclic_sr_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = 4,
  parameter int ROT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef CYCLIC_LOADER_FLUSH_EN
  input  logic                   flush,
`endif
  cyclic_sr_loader_if.slave      bus,
  output logic [WIDTH-1:0]       D,
  output logic                   en,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  localparam int RW = cnt_w(ROT_CYCLES);

  state_t           state, state_nxt;
  logic [RW-1:0]    rot_cnt, rot_nxt;
  logic [WIDTH-1:0] d_nxt, head;
  logic             en_nxt, pop, fifo_full, fifo_empty, push, flush_i;

`ifdef CYCLIC_LOADER_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // in_ready comes from the registered level only; no path from in_valid.
  assign bus.in_ready = ~fifo_full;
  assign push         = bus.in_valid & ~fifo_full;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (flush_i),
    .push  (push),
    .pop   (pop),
    .din   (bus.in_data),
    .dout  (head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register (with the registered outputs that move alongside it).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      D       <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      rot_cnt <= '0;
    end else begin
      state   <= state_nxt;
      D       <= d_nxt;
      en      <= en_nxt;
      busy    <= (state_nxt != ST_IDLE);
      rot_cnt <= rot_nxt;
    end
  end

  // Next state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_ROTATE;
      ST_ROTATE: if (rot_cnt == '0) state_nxt = fifo_empty ? ST_IDLE : ST_LOAD;
      default:   state_nxt = ST_IDLE;
    endcase
    if (flush_i) state_nxt = ST_IDLE;
  end

  // Outputs: pop strobe and next values of D/en/rot_cnt.
  always_comb begin
    pop     = 1'b0;
    d_nxt   = D;
    en_nxt  = 1'b0;
    rot_nxt = rot_cnt;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          d_nxt  = head;
          en_nxt = 1'b1;
        end
      end
      ST_LOAD: rot_nxt = RW'(ROT_CYCLES - 1);
      ST_ROTATE: begin
        if (rot_cnt != '0) begin
          rot_nxt = rot_cnt - RW'(1);
        end else if (!fifo_empty) begin
          // Next word loads straight out of ROTATE, no idle cycle.
          pop    = 1'b1;
          d_nxt  = head;
          en_nxt = 1'b1;
        end
      end
      default: ;
    endcase
    if (flush_i) begin
      pop     = 1'b0;
      d_nxt   = D;
      en_nxt  = 1'b0;
      rot_nxt = '0;
    end
  end

endmodule

// File: tb/tb_cyclic_sr_loader.sv
module tb_cyclic_sr_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] D;
  logic       en, busy;
  logic [2:0] level;
`ifdef CYCLIC_LOADER_FLUSH_EN
  logic       flush = 1'b0;
`endif

  cyclic_sr_loader_if #(.WIDTH(4)) bus ();

  cyclic_sr_loader #(.WIDTH(4), .DEPTH(4), .ROT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef CYCLIC_LOADER_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus),
    .D     (D),
    .en    (en),
    .busy  (busy),
    .level (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int load_d[$];
  int load_c[$];

  always @(posedge clk) cyc++;
  // Record every load pulse, sampled mid-cycle.
  always @(negedge clk) if (en === 1'b1) begin
    load_d.push_back(int'(D));
    load_c.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] v);
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bit rdy, saw_full, bad_rdy, tmo, bad_gap;
    int v, guard;

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;

    // Reset values
    step(3);
    chk("rst_D", D, 0);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", bus.in_ready, 1);
    reset = 1'b1;
    step(10);
    chk("idle_busy", busy, 0);
    chk("idle_level", level, 0);
    chk("idle_loads", load_d.size(), 0);

    // Single word latency
    load_d.delete(); load_c.delete();
    push(4'hA);
    chk("single_lvl1", level, 1);
    chk("single_en_k", en, 0);
    step();
    chk("single_en", en, 1);
    chk("single_D", D, 4'hA);
    chk("single_busy", busy, 1);
    chk("single_lvl0", level, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("single_rot%0d_en", i), en, 0);
      chk($sformatf("single_rot%0d_busy", i), busy, 1);
    end
    chk("single_Dhold", D, 4'hA);
    step();
    chk("single_idle", busy, 0);
    chk("single_loads", load_d.size(), 1);

    // Back-to-back words
    load_d.delete(); load_c.delete();
    push(4'h1); push(4'h2); push(4'h3);
    step(20);
    chk("b2b_cnt", load_d.size(), 3);
    if (load_d.size() == 3) begin
      chk("b2b_d0", load_d[0], 1);
      chk("b2b_d1", load_d[1], 2);
      chk("b2b_d2", load_d[2], 3);
      chk("b2b_gap01", load_c[1] - load_c[0], 5);
      chk("b2b_gap12", load_c[2] - load_c[1], 5);
    end
    chk("b2b_idle", busy, 0);

    // Backpressure: stream 0..9 with in_valid held high
    load_d.delete(); load_c.delete();
    v = 0; guard = 0; saw_full = 0; bad_rdy = 0;
    while (v < 10 && guard < 200) begin
      bus.in_data  = 4'(v);
      bus.in_valid = 1'b1;
      rdy = bus.in_ready;
      if (!rdy && level == 3'd4) saw_full = 1;
      if (rdy == (level == 3'd4)) bad_rdy = 1;
      step();
      if (rdy) v++;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("bp_pushed", v, 10);
    chk("bp_saw_full", saw_full, 1);
    chk("bp_ready_rule", bad_rdy, 0);
    tmo = 1; guard = 0;
    while (guard < 300) begin
      if (!busy && level == 0) begin tmo = 0; break; end
      step();
      guard++;
    end
    chk("bp_drain_tmo", tmo, 0);
    chk("bp_cnt", load_d.size(), 10);
    bad_gap = 0;
    for (int i = 0; i < load_d.size(); i++) begin
      chk($sformatf("bp_d%0d", i), load_d[i], i);
      if (i > 0 && load_c[i] - load_c[i-1] != 5) bad_gap = 1;
    end
    chk("bp_spacing", bad_gap, 0);

    // Reset during ROTATE with level=2
    push(4'h7); push(4'h8); push(4'h9);
    chk("mid_level", level, 2);
    chk("mid_busy", busy, 1);
    chk("mid_D", D, 4'h7);
    chk("mid_en", en, 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_D", D, 0);
    chk("mid_rst_en", en, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    load_d.delete(); load_c.delete();
    step(2);
    reset = 1'b1;
    step(30);
    chk("mid_no_loads", load_d.size(), 0);
    chk("mid_level_after", level, 0);

`ifdef CYCLIC_LOADER_FLUSH_EN
    // Flush with level=3 in ROTATE and a concurrent push
    push(4'hB); push(4'hC); push(4'hD); push(4'hE);
    chk("fl_level", level, 3);
    chk("fl_busy", busy, 1);
    bus.in_data  = 4'hF;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_level0", level, 0);
    chk("fl_busy0", busy, 0);
    chk("fl_en0", en, 0);
    chk("fl_Dhold", D, 4'hB);
    load_d.delete(); load_c.delete();
    step(30);
    chk("fl_no_loads", load_d.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
